// File: rtl/intersection_phase_scheduler.sv
// Phase authority for a two-road intersection with a shared pedestrian crossing.
// Moore-decoded lights; greens hold at minimum until a competing request appears.
//
// state     | meaning
// ALLRED_NS | clearance before north-south green (or walk)
// NS_GREEN  | north-south green, extends while no competing request
// NS_YELLOW | north-south yellow
// ALLRED_EW | clearance before east-west green (or walk)
// EW_GREEN  | east-west green, extends while no competing request
// EW_YELLOW | east-west yellow
// PED_WALK  | all vehicle lights red, walk lamp lit
module intersection_phase_scheduler #(
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6,
  parameter int TW         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALLRED_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    ST_BAD    = 3'd7
  } state_e;

  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_CYC - 1);

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pending_q, ped_pending_d;
  logic          next_dir_q, next_dir_d;

  logic ped_set;
  logic ped_eff;
  logic hold_timer;

  // A press in the current cycle already counts for this cycle's decision.
  assign ped_set = ped_req && (state_q != PED_WALK);
  assign ped_eff = ped_pending_q || ped_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ALLRED_NS;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      next_dir_q    <= DIR_NS;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      next_dir_q    <= next_dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    hold_timer = 1'b0;

    case (state_q)
      ALLRED_NS: begin
        if (timer_q == ALLRED_LAST) begin
          if (ped_eff) begin
            state_d    = PED_WALK;
            next_dir_d = DIR_NS;
          end else begin
            state_d = NS_GREEN;
          end
        end
      end
      NS_GREEN: begin
        if (timer_q == GREEN_LAST) begin
          if (ew_req || ped_eff) state_d = NS_YELLOW;
          else                   hold_timer = 1'b1;
        end
      end
      NS_YELLOW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d    = ALLRED_EW;
          next_dir_d = DIR_EW;
        end
      end
      ALLRED_EW: begin
        if (timer_q == ALLRED_LAST) begin
          if (ped_eff) begin
            state_d    = PED_WALK;
            next_dir_d = DIR_EW;
          end else begin
            state_d = EW_GREEN;
          end
        end
      end
      EW_GREEN: begin
        if (timer_q == GREEN_LAST) begin
          if (ns_req || ped_eff) state_d = EW_YELLOW;
          else                   hold_timer = 1'b1;
        end
      end
      EW_YELLOW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d    = ALLRED_NS;
          next_dir_d = DIR_NS;
        end
      end
      PED_WALK: begin
        if (timer_q == WALK_LAST) begin
          state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
        end
      end
      default: state_d = ALLRED_NS;
    endcase
  end

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (state_d != state_q) timer_d = '0;
    else if (hold_timer)    timer_d = timer_q;
  end

  always_comb begin
    ped_pending_d = ped_pending_q;
    if (state_d == PED_WALK && state_q != PED_WALK) ped_pending_d = 1'b0;
    else if (ped_set)                               ped_pending_d = 1'b1;
  end

  always_comb begin
    ns_green  = (state_q == NS_GREEN);
    ns_yellow = (state_q == NS_YELLOW);
    ns_red    = !(ns_green || ns_yellow);
    ew_green  = (state_q == EW_GREEN);
    ew_yellow = (state_q == EW_YELLOW);
    ew_red    = !(ew_green || ew_yellow);
    walk      = (state_q == PED_WALK);
    phase     = state_q;
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed, table-driven bench for intersection_phase_scheduler.
// Each row holds inputs for N cycles and the phase expected in each of them.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] S_ANS = 3'd0, S_NSG = 3'd1, S_NSY = 3'd2, S_AEW = 3'd3,
                         S_EWG = 3'd4, S_EWY = 3'd5, S_WLK = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset),
    .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ns;
    logic       ew;
    logic       ped;
    int         n;
    logic [2:0] ph;
  } vec_t;

  vec_t vecs[$];

  logic [9:0] act_out;
  assign act_out = {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  function automatic logic [9:0] exp_out(logic [2:0] p);
    logic nsg, nsy, ewg, ewy;
    nsg = (p == S_NSG);
    nsy = (p == S_NSY);
    ewg = (p == S_EWG);
    ewy = (p == S_EWY);
    return {p, !(nsg || nsy), nsy, nsg, !(ewg || ewy), ewy, ewg, (p == S_WLK)};
  endfunction

  function automatic void add(logic ns, logic ew, logic ped, int n, logic [2:0] ph);
    vec_t v;
    v.ns = ns; v.ew = ew; v.ped = ped; v.n = n; v.ph = ph;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={phase,nsRYG,ewRYG,walk}=%b required=%b", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_seg(int first, int last);
    for (int r = first; r < last; r++) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        ns_req  = vecs[r].ns;
        ew_req  = vecs[r].ew;
        ped_req = vecs[r].ped;
        check($sformatf("row%0d_cyc%0d", r, c), act_out, exp_out(vecs[r].ph));
        @(negedge clk);
      end
    end
  endtask

  // Safety invariants on every sampled cycle outside reset.
  logic prev_nsg = 1'b0, prev_ewg = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_nsg <= 1'b0;
      prev_ewg <= 1'b0;
    end else begin
      checks++;
      if (($countones({ns_red, ns_yellow, ns_green}) != 1) ||
          ($countones({ew_red, ew_yellow, ew_green}) != 1) ||
          (ns_green && ew_green) || (prev_nsg && ew_green) || (prev_ewg && ns_green) ||
          (walk && (ns_green || ew_green || ns_yellow || ew_yellow))) begin
        errors++;
        $display("FAIL invariant actual=%b prev_nsg=%b prev_ewg=%b required=safe_lights",
                 act_out, prev_nsg, prev_ewg);
      end
      prev_nsg <= ns_green;
      prev_ewg <= ew_green;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int seg_a;

  initial begin
    // Idle after reset: clearance, then indefinite NS green.
    add(0, 0, 0,  2, S_ANS);
    add(0, 0, 0, 40, S_NSG);
    // Both roads requesting: strict 30-cycle alternation, twice.
    add(1, 1, 0,  1, S_NSG);
    for (int k = 0; k < 2; k++) begin
      add(1, 1, 0,  3, S_NSY);
      add(1, 1, 0,  2, S_AEW);
      add(1, 1, 0, 10, S_EWG);
      add(1, 1, 0,  3, S_EWY);
      add(1, 1, 0,  2, S_ANS);
      if (k == 0) add(1, 1, 0, 10, S_NSG);
    end
    // Single-cycle press at NS green timer 4.
    add(0, 0, 0,  4, S_NSG);
    add(0, 0, 1,  1, S_NSG);
    add(0, 0, 0,  5, S_NSG);
    add(0, 0, 0,  3, S_NSY);
    add(0, 0, 0,  2, S_AEW);
    add(0, 0, 0,  6, S_WLK);
    // Press at EW green start; held through walk must not retrigger.
    add(0, 0, 1,  1, S_EWG);
    add(0, 0, 0,  9, S_EWG);
    add(0, 0, 0,  3, S_EWY);
    add(0, 0, 0,  2, S_ANS);
    add(0, 0, 1,  6, S_WLK);
    // NS green minimum plus 5 extension cycles, then ew_req at expiry.
    add(0, 0, 0, 15, S_NSG);
    add(0, 1, 0,  1, S_NSG);
    add(0, 1, 0,  3, S_NSY);
    add(0, 1, 0,  2, S_AEW);
    // EW green timers 0..6 with a press that reset must discard.
    add(0, 0, 0,  2, S_EWG);
    add(0, 0, 1,  1, S_EWG);
    add(0, 0, 0,  4, S_EWG);
    seg_a = vecs.size();
    // After reset release: no walk, then press at the green expiry cycle.
    add(0, 0, 0,  2, S_ANS);
    add(0, 0, 0, 12, S_NSG);
    add(0, 0, 1,  1, S_NSG);
    add(0, 0, 0,  3, S_NSY);
    add(0, 0, 0,  2, S_AEW);
    add(0, 0, 0,  6, S_WLK);
    add(0, 0, 0,  3, S_EWG);

    #1;
    check("reset_state", act_out, exp_out(S_ANS));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_seg(0, seg_a);

    // Now at EW green timer 7: reset must clear lights before the next edge.
    check("pre_reset_ew_green", act_out, exp_out(S_EWG));
    #1 reset = 1'b1;
    #1 check("async_reset_allred", act_out, exp_out(S_ANS));
    @(negedge clk);
    check("reset_held", act_out, exp_out(S_ANS));
    @(negedge clk);
    reset = 1'b0;
    run_seg(seg_a, vecs.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

- Sequences a two-road intersection (north-south, east-west) plus a pedestrian crossing.
- Drives one red/yellow/green set per road and a walk signal, sharing the crossing between vehicle and pedestrian requesters.
- Green phases last a configurable minimum and are extended while no competing request exists.
- Sits above the per-road light outputs as the single phase authority; no other block drives the lights.

## Interface
- GREEN_CYC, 10, minimum green duration in cycles (>=1)
- YELLOW_CYC, 3, yellow duration in cycles (>=1)
- ALLRED_CYC, 2, all-red clearance duration in cycles (>=1)
- WALK_CYC, 6, pedestrian walk duration in cycles (>=1)
- TW, 4, phase timer width; every duration parameter must be <= 2^TW
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- ns_req  input  1  vehicle waiting on north-south (level)
- ew_req  input  1  vehicle waiting on east-west (level)
- ped_req  input  1  pedestrian button (any width pulse)
- ns_red, ns_yellow, ns_green  output  1 each  north-south lights
- ew_red, ew_yellow, ew_green  output  1 each  east-west lights
- walk  output  1  pedestrian walk lamp
- phase  output  3  current state encoding (debug/observe)

## Operation
- States and encodings:
  - ALLRED_NS=0
  - NS_GREEN=1
  - NS_YELLOW=2
  - ALLRED_EW=3
  - EW_GREEN=4
  - EW_YELLOW=5
  - PED_WALK=6
  - Encoding 7 is illegal and goes to ALLRED_NS on the next edge.
- Outputs are a Moore decode of the state register:
  - ns_green only in NS_GREEN; ns_yellow only in NS_YELLOW; ns_red in every other state.
  - ew_green and ew_yellow likewise for EW_GREEN and EW_YELLOW; ew_red otherwise.
  - walk=1 only in PED_WALK.
  - At most one light per road is ever lit.
- Timer: resets to 0 on every state change and increments each cycle in a state. "Expiry" means timer == DUR-1 of the current state.
- ped_pending register:
  - Set on any cycle with ped_req=1, except while in PED_WALK, where ped_req is ignored.
  - Cleared on entry to PED_WALK.
- next_dir register: records which green follows the clearance or walk. It is written when leaving a yellow.
- Transitions:
  - ALLRED_NS, at expiry:
    - ped_pending=1: go to PED_WALK with next_dir=NS.
    - Otherwise: go to NS_GREEN.
  - NS_GREEN, at expiry:
    - ew_req=1 or ped_pending=1: go to NS_YELLOW.
    - Otherwise: stay, with the timer held at GREEN_CYC-1 (extension).
  - NS_YELLOW, at expiry: go to ALLRED_EW.
  - ALLRED_EW: mirror of ALLRED_NS, targeting EW_GREEN.
  - EW_GREEN: mirror of NS_GREEN, using ns_req.
  - EW_YELLOW, at expiry: go to ALLRED_NS.
  - PED_WALK, at expiry: go directly to the green named by next_dir (NS_GREEN or EW_GREEN).
- Simultaneous events:
  - ped_req arriving in the same cycle as green expiry counts as pending for that expiry decision, i.e. the pending set is visible combinationally.
  - Both ns_req and ew_req high: strict alternation.

## Timing
- On reset assertion, asynchronously and immediately:
  - state=ALLRED_NS, timer=0, ped_pending=0, next_dir=NS.
  - Outputs become ns_red=1, ew_red=1, all yellows and greens 0, walk=0, phase=0.
- Reset mid-phase: the same values apply immediately. Any pending pedestrian request is discarded.
- Each state occupies exactly its DUR clock edges; green occupies at least GREEN_CYC.
- First NS_GREEN begins on the ALLRED_CYC-th rising edge after reset release.
- Request latency: the request is sampled at green expiry. Yellow appears on the following edge.
- A green, yellow and other road's green never coexist; all-red separates every green change.

## Test plan
- Reset, then release with all requests 0:
  - phase=0 for 2 cycles, then NS_GREEN held for 40 cycles.
  - ew_* stays red throughout.
- ew_req=ns_req=1 constant:
  - Periodic 30-cycle sequence: NS_GREEN 10, NS_YELLOW 3, ALLRED_EW 2, EW_GREEN 10, EW_YELLOW 3, ALLRED_NS 2.
  - walk stays 0.
- 1-cycle ped_req at timer=4 of NS_GREEN, no vehicle requests:
  - NS_GREEN ends at 10 cycles, then NS_YELLOW 3 and ALLRED_EW 2.
  - Then PED_WALK 6 with walk=1 and all lights red.
  - Then EW_GREEN.
- ped_req asserted throughout PED_WALK:
  - Next green runs uninterrupted to minimum.
  - No repeat walk unless ped_req recurs after walk ends.
- Asynchronous reset mid EW_GREEN at timer=7:
  - Outputs go all-red before the next edge.
  - After release, NS_GREEN follows 2 cycles later.
- ew_req rises the same cycle as NS_GREEN expiry after a 5-cycle extension:
  - NS_YELLOW appears on the next edge.
  - Assertion checks: no two greens together; no direct green-to-green change.
